// File: rtl/dffram_ctrl_wrap.sv
`default_nettype none
// ============================================================================
//  Module   : dffram_ctrl_wrap
//  Brief    : WSIZE-byte x DEPTH single-port flop RAM with byte write enables,
//             req/gnt handshake, 1- or 2-cycle read latency with rvalid strobe,
//             out-of-range error flag and a hardware clear sequencer.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module dffram_ctrl_wrap #(
  parameter int WSIZE          = 4,
  parameter int DEPTH          = 1024,
  parameter int ADDRWIDTH      = $clog2(DEPTH),
  parameter int READ_LAT       = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  output logic                 busy_o,
  input  logic                 req_i,
  input  logic [WSIZE-1:0]     we_i,
  input  logic [ADDRWIDTH-1:0] addr_i,
  input  logic [WSIZE*8-1:0]   wdata_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [WSIZE*8-1:0]   rdata_o,
  output logic                 err_o
);

  localparam int DW = WSIZE * 8;
  // One extra bit on all index arithmetic so DEPTH-1 / DEPTH compare without wrap.
  localparam logic [ADDRWIDTH:0] LAST_ADDR = (ADDRWIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDRWIDTH:0] DEPTH_W   = (ADDRWIDTH + 1)'(DEPTH);
  localparam logic [ADDRWIDTH:0] CNT_ONE   = (ADDRWIDTH + 1)'(1);

  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ADDRWIDTH:0]   cnt_q, cnt_d;
  logic [DW-1:0]        mem [DEPTH];

  logic                 in_range;
  logic                 wr_en;
  logic                 rd_en;

  logic                 s1_valid;
  logic                 s1_err;
  logic [DW-1:0]        s1_data;

  assign in_range = ({1'b0, addr_i} < DEPTH_W);
  assign busy_o   = (state_q == ST_CLEAR);
  // A clear pulse in READY takes priority over a same-cycle request.
  assign gnt_o    = rst_ni & req_i & (state_q == ST_READY) & ~clear_i;
  assign wr_en    = gnt_o & (|we_i) & in_range;
  assign rd_en    = gnt_o & ~(|we_i);

  // State and clear-counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: clear walks cnt from 0 to DEPTH-1, one word per cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_READY: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_READY;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage array: clear writes zero at cnt, otherwise granted byte-masked writes.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_CLEAR) begin
      mem[cnt_q[ADDRWIDTH-1:0]] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < WSIZE; b++) begin
        if (we_i[b]) begin
          mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // First read stage: data sampled at the grant edge; data holds between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_en;
      s1_err   <= rd_en & ~in_range;
      if (rd_en) begin
        s1_data <= in_range ? mem[addr_i] : '0;
      end
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic          s2_valid;
    logic          s2_err;
    logic [DW-1:0] s2_data;

    // Extra output register stage for the two-cycle latency variant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s2_valid <= 1'b0;
        s2_err   <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        s2_err   <= s1_err;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign rvalid_o = s2_valid;
    assign err_o    = s2_err;
    assign rdata_o  = s2_data;
  end else begin : g_lat1
    assign rvalid_o = s1_valid;
    assign err_o    = s1_err;
    assign rdata_o  = s1_data;
  end

endmodule
`default_nettype wire
